// File: rtl/bnn_layer_seq.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// bnn_layer_seq
//
// Binary dense layer with N_OUT neurons of N_IN weights each. Every neuron
// computes popcount(~(in ^ W[k])) and fires when that count is >= its
// threshold T[k]. A single popcount datapath is time-multiplexed over the
// neurons, one neuron per enabled clock, so a run takes N_OUT cycles.
//
// Weights and thresholds are loaded at runtime as a stream of LW-bit chunks.
// Each neuron's record is {pad, T[TW-1:0], W[N_IN-1:0]} sent LSB-first in
// CPN chunks; neuron 0 first. Bits land in storage as each chunk is accepted.
//
// Ports
//   clk         in   1      clock, rising edge
//   reset       in   1      asynchronous, active-high reset
//   ena         in   1      global enable; low freezes all state
//   load_valid  in   1      load chunk valid
//   load_data   in   LW     load chunk
//   load_ready  out  1      chunk accepted when load_valid & load_ready
//   load_done   out  1      1-cycle pulse: last chunk of last neuron accepted
//   start       in   1      evaluation request, sampled only in IDLE
//   in_vec      in   N_IN   input activations, captured on accepted start
//   busy        out  1      evaluation in progress
//   out_valid   out  1      1-cycle pulse: out_vec updated
//   out_vec     out  N_OUT  neuron outputs, bit k = neuron k; held between runs
// ---------------------------------------------------------------------------
module bnn_layer_seq #(
    parameter int N_IN  = 8,
    parameter int N_OUT = 8,
    parameter int LW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ena,
    input  logic             load_valid,
    input  logic [LW-1:0]    load_data,
    output logic             load_ready,
    output logic             load_done,
    input  logic             start,
    input  logic [N_IN-1:0]  in_vec,
    output logic             busy,
    output logic             out_valid,
    output logic [N_OUT-1:0] out_vec
);

    localparam int TW  = $clog2(N_IN + 1);           // popcount / threshold width
    localparam int RW  = N_IN + TW;                  // meaningful record bits
    localparam int CPN = (RW + LW - 1) / LW;         // chunks per neuron
    localparam int KW  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int CW  = (CPN > 1) ? $clog2(CPN) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_reg;
    logic [KW-1:0]     k_reg;
    logic [N_IN-1:0]   in_reg;
    logic [N_OUT-1:0]  res_reg;
    logic [N_OUT-1:0]  res_next;

    logic [KW-1:0]     ptr_neuron_reg;
    logic [CW-1:0]     ptr_chunk_reg;

    logic [N_IN-1:0]   w_arr [N_OUT];
    logic [TW-1:0]     t_arr [N_OUT];

    logic              load_fire;
    logic              last_chunk;
    logic              last_neuron;

    // ------------------------------------------------------------------
    // Load handshake. start wins over a chunk offered in the same cycle,
    // which is why ~start gates ready.
    // ------------------------------------------------------------------
    assign load_ready  = (state_reg == IDLE) & ena & ~start;
    assign load_fire   = load_valid & load_ready;
    assign last_chunk  = (ptr_chunk_reg == CW'(CPN - 1));
    assign last_neuron = (ptr_neuron_reg == KW'(N_OUT - 1));
    assign busy        = (state_reg == RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_neuron_reg <= '0;
            ptr_chunk_reg  <= '0;
            load_done      <= 1'b0;
        end else begin
            // Pulse is regenerated every edge; a disabled edge cannot
            // accept a chunk, so it also cannot produce a pulse.
            load_done <= load_fire & last_chunk & last_neuron;
            if (load_fire) begin
                if (last_chunk) begin
                    ptr_chunk_reg  <= '0;
                    ptr_neuron_reg <= last_neuron ? '0 : ptr_neuron_reg + 1'b1;
                end else begin
                    ptr_chunk_reg  <= ptr_chunk_reg + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-neuron record storage. Record bit b belongs to chunk b/LW at
    // lane b%LW; only the bits of the chunk being accepted are written,
    // so a partially reloaded neuron mixes old and new bits. Pad lanes
    // of the final chunk have no storage.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < N_OUT; gi++) begin : gen_neuron
            logic [RW-1:0] rec_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rec_reg <= '0;
                end else if (load_fire && (ptr_neuron_reg == KW'(gi))) begin
                    for (int b = 0; b < RW; b++) begin
                        if (ptr_chunk_reg == CW'(b / LW)) begin
                            rec_reg[b] <= load_data[b % LW];
                        end
                    end
                end
            end

            assign w_arr[gi] = rec_reg[N_IN-1:0];
            assign t_arr[gi] = rec_reg[RW-1:N_IN];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Shared evaluation datapath for neuron k_reg.
    // ------------------------------------------------------------------
    logic [N_IN-1:0] w_sel;
    logic [TW-1:0]   t_sel;
    logic [N_IN-1:0] match_vec;
    logic [TW-1:0]   sum;
    logic            fire;

    always_comb begin
        w_sel     = w_arr[k_reg];
        t_sel     = t_arr[k_reg];
        match_vec = ~(in_reg ^ w_sel);
        sum       = '0;
        for (int i = 0; i < N_IN; i++) begin
            sum = sum + TW'(match_vec[i]);
        end
        // Unsigned compare: T=0 always fires, T>N_IN never fires.
        fire      = (sum >= t_sel);
        res_next  = res_reg;
        res_next[k_reg] = fire;
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            k_reg     <= '0;
            in_reg    <= '0;
            res_reg   <= '0;
            out_vec   <= '0;
            out_valid <= 1'b0;
        end else begin
            // Default low so the pulse lasts exactly one cycle and never
            // appears after a disabled edge.
            out_valid <= 1'b0;
            if (ena) begin
                case (state_reg)
                    IDLE: begin
                        if (start) begin
                            in_reg    <= in_vec;
                            k_reg     <= '0;
                            state_reg <= RUN;
                        end
                    end
                    RUN: begin
                        res_reg <= res_next;
                        if (k_reg == KW'(N_OUT - 1)) begin
                            out_vec   <= res_next;
                            out_valid <= 1'b1;
                            state_reg <= IDLE;
                        end else begin
                            k_reg <= k_reg + 1'b1;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bnn_layer_seq.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_bnn_layer_seq
//
// Directed bench for bnn_layer_seq with N_IN=8, N_OUT=4, LW=4 (TW=4, CPN=3).
// Stimulus pushes the hand-computed out_vec for each run into a queue; a
// separate monitor pops and compares whenever out_valid is seen. Timing and
// handshake details are checked inline by the stimulus thread.
//
// Stored layer used for most runs (W, T):
//   n0: 0xF0, 5   n1: 0x00, 0   n2: 0xFF, 9   n3: 0xA5, 4
// ---------------------------------------------------------------------------
module tb_bnn_layer_seq;

    localparam int N_IN  = 8;
    localparam int N_OUT = 4;
    localparam int LW    = 4;
    localparam int CPN   = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             ena;
    logic             load_valid;
    logic [LW-1:0]    load_data;
    logic             load_ready;
    logic             load_done;
    logic             start;
    logic [N_IN-1:0]  in_vec;
    logic             busy;
    logic             out_valid;
    logic [N_OUT-1:0] out_vec;

    bnn_layer_seq #(
        .N_IN (N_IN),
        .N_OUT(N_OUT),
        .LW   (LW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ena       (ena),
        .load_valid(load_valid),
        .load_data (load_data),
        .load_ready(load_ready),
        .load_done (load_done),
        .start     (start),
        .in_vec    (in_vec),
        .busy      (busy),
        .out_valid (out_valid),
        .out_vec   (out_vec)
    );

    always #5 clk = ~clk;

    int               checks   = 0;
    int               failures = 0;
    logic [N_OUT-1:0] exp_q [$];
    logic [N_OUT-1:0] mon_exp;
    int               mn = 0;   // expected load pointer: neuron
    int               mc = 0;   // expected load pointer: chunk

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_chunk(input logic [LW-1:0] d);
        logic exp_done;
        chk("load_ready_before_chunk", 32'(load_ready), 32'd1);
        load_valid = 1'b1;
        load_data  = d;
        step();
        load_valid = 1'b0;
        exp_done = (mn == N_OUT - 1) && (mc == CPN - 1);
        if (mc == CPN - 1) begin
            mc = 0;
            mn = (mn == N_OUT - 1) ? 0 : mn + 1;
        end else begin
            mc++;
        end
        chk("load_done", 32'(load_done), 32'(exp_done));
        $display("chunk 0x%0h accepted load_done=%0b", d, load_done);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk("run_complete_busy", 32'(busy), 32'd0);
    endtask

    task automatic run(input logic [N_IN-1:0] v, input logic [N_OUT-1:0] e);
        in_vec = v;
        start  = 1'b1;
        exp_q.push_back(e);
        step();
        start = 1'b0;
        wait_idle();
        step();
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out_valid: got out_vec=0x%0h required no pulse", out_vec);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("out_vec", 32'(out_vec), 32'(mon_exp));
                $display("result out_vec=0x%0h required 0x%0h", out_vec, mon_exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        ena        = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        start      = 1'b0;
        in_vec     = '0;

        // 1. Reset state
        repeat (2) @(negedge clk);
        chk("reset_out_vec",   32'(out_vec),   32'd0);
        chk("reset_busy",      32'(busy),      32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_load_done", 32'(load_done), 32'd0);
        step();
        reset = 1'b0;
        step();
        chk("post_reset_load_ready", 32'(load_ready), 32'd1);

        // 2/4/5. Load all four neurons; load_done only on the 12th chunk.
        send_chunk(4'h0); send_chunk(4'hF); send_chunk(4'h5);   // W=F0 T=5
        send_chunk(4'h0); send_chunk(4'h0); send_chunk(4'h0);   // W=00 T=0
        send_chunk(4'hF); send_chunk(4'hF); send_chunk(4'h9);   // W=FF T=9
        send_chunk(4'h5); send_chunk(4'hA); send_chunk(4'h4);   // W=A5 T=4

        run(8'hF0, 4'hB);
        run(8'h0F, 4'hA);
        run(8'hFF, 4'hA);

        // 3. Latency, busy window, mid-RUN start/load/in_vec changes ignored.
        in_vec = 8'hF0;
        start  = 1'b1;
        exp_q.push_back(4'hB);
        step();                                     // edge t
        start = 1'b0;
        chk("t0_busy", 32'(busy), 32'd1);
        chk("t0_out_valid", 32'(out_valid), 32'd0);
        step();                                     // edge t+1
        chk("t1_busy", 32'(busy), 32'd1);
        start      = 1'b1;
        load_valid = 1'b1;
        load_data  = 4'hC;
        in_vec     = 8'h00;
        #1;
        chk("run_load_ready", 32'(load_ready), 32'd0);
        step();                                     // edge t+2
        start      = 1'b0;
        load_valid = 1'b0;
        chk("t2_busy", 32'(busy), 32'd1);
        chk("t2_out_valid", 32'(out_valid), 32'd0);
        step();                                     // edge t+3
        chk("t3_busy", 32'(busy), 32'd1);
        chk("t3_out_valid", 32'(out_valid), 32'd0);
        step();                                     // edge t+4
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_out_valid", 32'(out_valid), 32'd1);
        // Back-to-back start while out_valid is high.
        in_vec = 8'hF0;
        start  = 1'b1;
        exp_q.push_back(4'hB);
        step();
        start = 1'b0;
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_pulse_cleared", 32'(out_valid), 32'd0);
        wait_idle();
        step();

        // 13th chunk lands in neuron0 W[3:0] (pointer was not moved mid-RUN).
        send_chunk(4'h3);                           // n0: W=F3 T=5
        run(8'hF3, 4'hB);

        // 6a. ena low for two cycles mid-RUN stretches latency to t+6.
        in_vec = 8'hF3;
        start  = 1'b1;
        exp_q.push_back(4'hB);
        step();                                     // edge t
        start = 1'b0;
        step();                                     // edge t+1
        chk("ena_t1_out_valid", 32'(out_valid), 32'd0);
        ena = 1'b0;
        step();                                     // edge t+2 (disabled)
        chk("ena_t2_busy", 32'(busy), 32'd1);
        chk("ena_t2_out_valid", 32'(out_valid), 32'd0);
        step();                                     // edge t+3 (disabled)
        chk("ena_t3_out_valid", 32'(out_valid), 32'd0);
        ena = 1'b1;
        step();                                     // edge t+4
        chk("ena_t4_out_valid", 32'(out_valid), 32'd0);
        step();                                     // edge t+5
        chk("ena_t5_out_valid", 32'(out_valid), 32'd0);
        chk("ena_t5_busy", 32'(busy), 32'd1);
        step();                                     // edge t+6
        chk("ena_t6_out_valid", 32'(out_valid), 32'd1);
        chk("ena_t6_busy", 32'(busy), 32'd0);
        step();

        // 6b. Reset mid-RUN aborts with no pulse and clears storage.
        in_vec = 8'h0F;
        start  = 1'b1;
        step();                                     // edge t
        start = 1'b0;
        step();                                     // edge t+1
        step();                                     // edge t+2
        reset = 1'b1;
        #1;
        chk("abort_busy",      32'(busy),      32'd0);
        chk("abort_out_vec",   32'(out_vec),   32'd0);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        mn = 0;
        mc = 0;
        step();
        step();
        reset = 1'b0;
        repeat (4) step();
        chk("abort_no_pulse_out_valid", 32'(out_valid), 32'd0);
        chk("abort_load_ready", 32'(load_ready), 32'd1);

        // All W=0, T=0 after reset: every neuron fires.
        run(8'h00, 4'hF);
        run(8'h5A, 4'hF);

        repeat (3) step();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
